uart_rx_responder: RTL and testbench
====================================

Name: uart_rx_responder

Overview:
- Serial receive end of the UART path that the CPU bus reaches through the memory controller.
- Deserialises 8N1 frames from the rx pin and presents each byte zero-extended to 32 bits, with a sticky "byte ready" flag.
- The flag is cleared by a one-cycle clear pulse from the bus side.
- Drives the memory controller's uart_rddata and uart_rx_flag inputs and consumes its uart_rx_clear output.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_clear  input  1  one-cycle pulse; clears rx_flag and overrun_err.
- rx_data  output  32  last received byte in [7:0]; [31:8] always 0.
- rx_flag  output  1  high while an unread byte is held.
- rx_busy  output  1  high while a frame is in progress (state != IDLE).
- frame_err  output  1  sticky; set when the stop bit samples 0.
- overrun_err  output  1  sticky; set when a byte completes while rx_flag = 1.

Behaviour:
- Reset (rst = 0, asynchronous):
  - rx_data = 0, rx_flag = 0, rx_busy = 0, frame_err = 0, overrun_err = 0.
  - State = IDLE, all counters = 0, synchroniser flops = 1.
- Input synchroniser: rx passes through 2 flops; rx_s is the second flop. Only rx_s is used internally.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer truncation; default 27.
  - The counter runs only when state != IDLE and is cleared on entry to START.
  - tick is a one-cycle pulse every DIV clocks.
- State machine:
  - IDLE: rx_s = 0 -> START, clear tick and sample counters.
  - START: after OVERSAMPLE/2 ticks (mid start bit), sample rx_s. If 1 (glitch) -> IDLE with no flag change. If 0 -> DATA, bit index = 0, sample counter = 0.
  - DATA: every OVERSAMPLE ticks, shift rx_s into the shift register LSB-first and increment the bit index. After bit 7 -> STOP (or PARITY, see the optional feature).
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - If 1: rx_data[7:0] <= shift register, rx_flag <= 1; if rx_flag was already 1, overrun_err <= 1 and the old byte is overwritten.
    - If 0: frame_err <= 1; rx_data and rx_flag are unchanged.
    - Either way -> IDLE on the same cycle.
- Latency: rx_flag rises 1 clk after the stop-bit mid-sample tick; nominally 9.5 bit periods plus 2 synchroniser clks after the start falling edge.
- Bit period = DIV*OVERSAMPLE clocks; default 432.
- rx_clear:
  - Clears rx_flag and overrun_err on the next edge.
  - frame_err clears only by reset or by a subsequent good frame.
- Simultaneous rx_clear and byte completion on the same edge: the completion wins. rx_flag stays 1, rx_data takes the new byte, overrun_err is not set.
- rx_clear while rx_busy = 1: no effect on the frame in progress.
- An rx line held low after a frame error: IDLE re-enters START immediately. The next frame is lost until the line returns high; no lock-up.
- Reset mid-frame: the partial byte is discarded and the block returns to IDLE immediately.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP that samples one even-parity bit after OVERSAMPLE ticks.
  - On mismatch, parity_err (extra output, 1 bit, sticky, cleared by rx_clear) is set. The byte is still delivered and rx_flag is still set.
  - The frame is 8E1.
- Undefined: no PARITY state, no parity_err port; the frame is 8N1.

Test Plan:
- Default params, send 0x55 as 8N1 at 432 clks/bit -> rx_data = 0x00000055, rx_flag = 1 at about clk 4106 after the start edge; frame_err = 0.
- Send 0xA3, pulse rx_clear, send 0x3C without clearing -> after the second frame, rx_data = 0x0000003C, rx_flag = 1, overrun_err = 0. Then send 0x7E without clearing -> rx_data = 0x0000007E, overrun_err = 1.
- Drive rx low for 100 clks then high -> rx_busy pulses, rx_flag stays 0, rx_data unchanged.
- Send 0xFF with the stop bit forced 0 -> frame_err = 1, rx_flag = 0, rx_data unchanged. Then send a good 0x01 -> frame_err = 0, rx_data = 0x00000001.
- Assert rx_clear on the exact cycle rx_flag would rise for 0x42 (rx_flag previously 1) -> rx_flag = 1, rx_data = 0x00000042, overrun_err = 0.
- Assert rst low during data bit 4 of a frame -> all outputs 0 asynchronously. After release, a clean 0x99 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_responder.sv
// +-----------------------------------------------------------------------------+
// | uart_rx_responder: 8N1 UART receiver with sticky byte-ready/error flags.     |
// | Optional macro UART_RX_PARITY_EN turns the frame into 8E1 (adds parity_err). |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module uart_rx_responder #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   input  logic        rx_clear,
   output logic [31:0] rx_data,
   output logic        rx_flag,
   output logic        rx_busy,
   output logic        frame_err,
`ifdef UART_RX_PARITY_EN
   output logic        parity_err,
`endif
   output logic        overrun_err
);

   localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
   localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t          state_q, state_d;
   logic            sync1_q, sync2_q;
   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [SW-1:0]   samp_cnt_q, samp_cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            flag_q, flag_d;
   logic            frame_err_q, frame_err_d;
   logic            overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
   logic            parity_err_q, parity_err_d;
`endif
   logic            rx_s;
   logic            tick;

   assign rx_s = sync2_q;
   assign tick = (state_q != S_IDLE) && (tick_cnt_q == TICK_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         tick_cnt_q   <= '0;
         samp_cnt_q   <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         flag_q       <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         sync1_q      <= rx;
         sync2_q      <= sync1_q;
         tick_cnt_q   <= tick_cnt_d;
         samp_cnt_q   <= samp_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         flag_q       <= flag_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      samp_cnt_d  = samp_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      flag_d      = flag_q;
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
      parity_err_d = parity_err_q;
`endif

      if (state_q == S_IDLE || tick) tick_cnt_d = '0;
      else                           tick_cnt_d = tick_cnt_q + TW'(1);

      // Clear is applied first so that a completing frame on the same edge wins.
      if (rx_clear) begin
         flag_d    = 1'b0;
         overrun_d = 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_d = 1'b0;
`endif
      end

      case (state_q)
         S_IDLE: begin
            samp_cnt_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            if (tick) begin
               if (samp_cnt_q == HALF_LAST) begin
                  samp_cnt_d = '0;
                  bit_idx_d  = '0;
                  state_d    = rx_s ? S_IDLE : S_DATA;
               end else begin
                  samp_cnt_d = samp_cnt_q + SW'(1);
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (samp_cnt_q == FULL_LAST) begin
                  samp_cnt_d = '0;
                  shift_d    = {rx_s, shift_q[7:1]};
                  bit_idx_d  = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                  if (bit_idx_q == 3'd7) state_d = S_PARITY;
`else
                  if (bit_idx_q == 3'd7) state_d = S_STOP;
`endif
               end else begin
                  samp_cnt_d = samp_cnt_q + SW'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               if (samp_cnt_q == FULL_LAST) begin
                  samp_cnt_d = '0;
                  if (rx_s != ^shift_q) parity_err_d = 1'b1;
                  state_d = S_STOP;
               end else begin
                  samp_cnt_d = samp_cnt_q + SW'(1);
               end
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (samp_cnt_q == FULL_LAST) begin
                  samp_cnt_d = '0;
                  state_d    = S_IDLE;
                  if (rx_s) begin
                     data_d      = shift_q;
                     flag_d      = 1'b1;
                     frame_err_d = 1'b0;
                     if (flag_q && !rx_clear) overrun_d = 1'b1;
                  end else begin
                     frame_err_d = 1'b1;
                  end
               end else begin
                  samp_cnt_d = samp_cnt_q + SW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rx_data     = {24'd0, data_q};
   assign rx_flag     = flag_q;
   assign rx_busy     = (state_q != S_IDLE);
   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = parity_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_responder.sv
// +-----------------------------------------------------------------------------+
// | tb_uart_rx_responder: self-checking bench for uart_rx_responder (8N1 build). |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_responder;

   localparam int CLK_FREQ = 50_000_000;
   localparam int BAUD     = 115200;
   localparam int OS       = 16;
   localparam int BIT      = (CLK_FREQ / (BAUD * OS)) * OS;
   // 2 synchroniser clks, 1 clk to leave IDLE, 9.5 bit periods to the stop mid-sample.
   localparam int EXP_LAT  = 3 + (19 * BIT) / 2;
   localparam int STOP_LOW_END = 9 * BIT + (3 * BIT) / 4;
   localparam int GAP      = 300;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic        rx_clear;
   logic [31:0] rx_data;
   logic        rx_flag;
   logic        rx_busy;
   logic        frame_err;
   logic        overrun_err;

   int n_checks = 0;
   int n_fail   = 0;
   int lat;
   bit saw_busy;

   logic [7:0] m_data;
   bit         m_flag, m_ovr, m_ferr;

   always #5 clk = ~clk;

   uart_rx_responder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rx_clear   (rx_clear),
      .rx_data    (rx_data),
      .rx_flag    (rx_flag),
      .rx_busy    (rx_busy),
      .frame_err  (frame_err),
      .overrun_err(overrun_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".data"},  rx_data,            {24'd0, m_data});
      chk({tag, ".flag"},  32'(rx_flag),       32'(m_flag));
      chk({tag, ".ovr"},   32'(overrun_err),   32'(m_ovr));
      chk({tag, ".ferr"},  32'(frame_err),     32'(m_ferr));
      chk({tag, ".busy"},  32'(rx_busy),       32'd0);
   endtask

   // Frame-level outcome: a clear at offset < EXP_LAT-1 lands before completion,
   // EXP_LAT-1 coincides with it, anything later lands after it.
   task automatic model_frame(input logic [7:0] b, input bit good, input int clear_at);
      bit same;
      same = (clear_at == EXP_LAT - 1);
      if (clear_at >= 0 && clear_at < EXP_LAT - 1) begin
         m_flag = 0; m_ovr = 0;
      end
      if (good) begin
         if (same) m_ovr = 0;
         else if (m_flag) m_ovr = 1;
         m_flag = 1; m_data = b; m_ferr = 0;
      end else begin
         m_ferr = 1;
         if (same) begin m_flag = 0; m_ovr = 0; end
      end
      if (clear_at > EXP_LAT - 1) begin m_flag = 0; m_ovr = 0; end
   endtask

   // Called just after a rising edge; rx at frame offset c is seen by edge c+1.
   task automatic send_frame(input logic [7:0] b, input bit good, input int clear_at);
      logic [9:0] bits;
      bits = {good, b, 1'b0};
      lat = -1; saw_busy = 0;
      for (int c = 0; c < 10 * BIT; c++) begin
         if (!good && c >= STOP_LOW_END) rx = 1'b1;
         else                            rx = bits[c / BIT];
         rx_clear = (c == clear_at);
         @(posedge clk); #1;
         if (rx_busy) saw_busy = 1;
         if (rx_flag && lat < 0) lat = c + 1;
      end
      rx = 1'b1; rx_clear = 1'b0;
      repeat (GAP) @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input string tag, input logic [7:0] b, input bit good, input int clear_at);
      model_frame(b, good, clear_at);
      send_frame(b, good, clear_at);
      check_all(tag);
   endtask

   task automatic pulse_clear();
      rx_clear = 1'b1;
      @(posedge clk); #1;
      rx_clear = 1'b0;
      m_flag = 0; m_ovr = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] rb;
      bit         rgood;
      int         rclr;
      logic [9:0] pbits;

      rst = 1'b0; rx = 1'b1; rx_clear = 1'b0;
      m_data = 8'h00; m_flag = 0; m_ovr = 0; m_ferr = 0;
      repeat (4) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      run_frame("f55", 8'h55, 1, -1);
      chk("latency", 32'(lat), 32'(EXP_LAT));

      run_frame("fA3", 8'hA3, 1, -1);
      pulse_clear();
      run_frame("f3C", 8'h3C, 1, -1);
      run_frame("f7E", 8'h7E, 1, -1);

      pulse_clear();
      check_all("clear");
      saw_busy = 0;
      rx = 1'b0;
      repeat (100) begin
         @(posedge clk); #1;
         if (rx_busy) saw_busy = 1;
      end
      rx = 1'b1;
      repeat (400) @(posedge clk);
      #1;
      chk("glitch.busy_seen", 32'(saw_busy), 32'd1);
      check_all("glitch");

      run_frame("fFF_bad", 8'hFF, 0, -1);
      run_frame("f01", 8'h01, 1, -1);

      run_frame("f42_same_clear", 8'h42, 1, EXP_LAT - 1);

      // Reset asserted mid data bit 4 of a frame.
      pbits = {1'b1, 8'hC6, 1'b0};
      for (int c = 0; c < 5 * BIT + BIT / 2; c++) begin
         rx = pbits[c / BIT];
         @(posedge clk); #1;
      end
      #3 rst = 1'b0;
      #1;
      m_data = 8'h00; m_flag = 0; m_ovr = 0; m_ferr = 0;
      check_all("async_rst");
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      run_frame("f99", 8'h99, 1, -1);

      for (int i = 0; i < 4; i++) begin
         rb    = 8'($urandom);
         rgood = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0:       rclr = -1;
            1:       rclr = EXP_LAT - 1;
            2:       rclr = int'($urandom_range(50, 3000));
            default: rclr = 4200;
         endcase
         run_frame($sformatf("rand%0d", i), rb, rgood, rclr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
